aes_rsp_collector: RTL and testbench

- Result-side counterpart to the request stimulus that drives aes_build's func/text_in/true_key.
- Tags every issued request, captures aes_build's ciphertext or plaintext when call_complete pulses, and returns an ordered, tagged response stream over a valid/ready handshake.
- Sits between aes_build and the host; owns credit so no completed result can ever be dropped.

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_rsp_collector_if.sv | 46 ++++
 rtl/aes_sync_fifo.sv | 64 ++++++
 rtl/aes_rsp_collector.sv | 121 ++++++++++++
 tb/tb_aes_rsp_collector.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types for the AES response collector.
// Func code, block width and tag/response bundles.
package aes_pkg;

  localparam int AES_BLK_W    = 128;
  localparam int FUNC_ENC_BIT = 0;
  localparam int RSP_ID_W     = 4;

  typedef logic [2:0] aes_func_t;

  typedef struct packed {
    aes_func_t             func;
    logic [RSP_ID_W-1:0]   id;
  } aes_tag_t;

  typedef struct packed {
    logic [AES_BLK_W-1:0]  data;
    aes_func_t             func;
    logic [RSP_ID_W-1:0]   id;
  } aes_rsp_t;

endpackage

// File: rtl/aes_rsp_collector_if.sv
// Host/core-facing bundle of the response collector.
// master = host/core side, slave = collector.
interface aes_rsp_collector_if
  import aes_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = RSP_ID_W
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 issue_valid;
  logic                 issue_ready;
  aes_func_t            issue_func;
  logic [ID_W-1:0]      issue_id;

  logic                 call_complete;
  logic [AES_BLK_W-1:0] ciphertext;
  logic [AES_BLK_W-1:0] plaintext;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [AES_BLK_W-1:0] rsp_data;
  aes_func_t            rsp_func;
  logic [ID_W-1:0]      rsp_id;

  logic [CNT_W-1:0]     outstanding;
  logic                 err_orphan;

  modport master (
    output issue_valid, issue_func, issue_id,
    output call_complete, ciphertext, plaintext,
    output rsp_ready,
    input  issue_ready, rsp_valid, rsp_data,
    input  rsp_func, rsp_id, outstanding, err_orphan
  );

  modport slave (
    input  issue_valid, issue_func, issue_id,
    input  call_complete, ciphertext, plaintext,
    input  rsp_ready,
    output issue_ready, rsp_valid, rsp_data,
    output rsp_func, rsp_id, outstanding, err_orphan
  );

endinterface

// File: rtl/aes_sync_fifo.sv
// Flop-based synchronous FIFO, same-cycle push/pop.
// Read data is the registered head entry.
module aes_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SIM
  // A push into a full FIFO with no pop would lose data.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && full && !pop))
        else $error("aes_sync_fifo push when full");
    end
  end
`endif

endmodule

// File: rtl/aes_rsp_collector.sv
// Tags AES requests and returns ordered, tagged results.
// Credit covers tags in flight plus buffered responses.
module aes_rsp_collector
  import aes_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = RSP_ID_W
) (
  input  logic            eph1,
  input  logic            reset,
  aes_rsp_collector_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  aes_tag_t         tag_wdata;
  aes_tag_t         tag_rdata;
  logic             tag_full;
  logic             tag_empty;
  logic [CNT_W-1:0] tag_count;

  aes_rsp_t         rsp_wdata;
  aes_rsp_t         rsp_rdata;
  logic             rsp_full;
  logic             rsp_empty;
  logic [CNT_W-1:0] rsp_count;

  logic             issue_fire;
  logic             tag_pop;
  logic             rsp_pop;
  logic [CNT_W-1:0] outstanding;
  logic             err_orphan;

  assign issue_fire = bus.issue_valid & bus.issue_ready;
  assign tag_pop    = bus.call_complete & ~tag_empty;
  assign rsp_pop    = bus.rsp_valid & bus.rsp_ready;

  assign tag_wdata.func = bus.issue_func;
  assign tag_wdata.id   = bus.issue_id;

  assign rsp_wdata.data = tag_rdata.func[FUNC_ENC_BIT]
                        ? bus.ciphertext
                        : bus.plaintext;
  assign rsp_wdata.func = tag_rdata.func;
  assign rsp_wdata.id   = tag_rdata.id;

  aes_sync_fifo #(
    .WIDTH ($bits(aes_tag_t)),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (eph1),
    .rst_n (reset),
    .push  (issue_fire),
    .wdata (tag_wdata),
    .pop   (tag_pop),
    .rdata (tag_rdata),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  aes_sync_fifo #(
    .WIDTH ($bits(aes_rsp_t)),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk   (eph1),
    .rst_n (reset),
    .push  (tag_pop),
    .wdata (rsp_wdata),
    .pop   (rsp_pop),
    .rdata (rsp_rdata),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  // Credit: +1 per issue, -1 per response pop.
  always_ff @(posedge eph1 or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      unique case ({issue_fire, rsp_pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Sticky flag for a completion with nothing pending.
  always_ff @(posedge eph1 or negedge reset) begin
    if (!reset) begin
      err_orphan <= 1'b0;
    end else if (bus.call_complete && tag_empty) begin
      err_orphan <= 1'b1;
    end
  end

  assign bus.issue_ready = (outstanding < CNT_W'(DEPTH));
  assign bus.outstanding = outstanding;
  assign bus.err_orphan  = err_orphan;
  assign bus.rsp_valid   = ~rsp_empty;
  assign bus.rsp_data    = rsp_rdata.data;
  assign bus.rsp_func    = rsp_rdata.func;
  assign bus.rsp_id      = rsp_rdata.id;

`ifdef SIM
  // Tags plus responses can never exceed the credit.
  always @(posedge eph1) begin
    if (reset) begin
      assert ((tag_count + rsp_count) <= outstanding)
        else $error("aes_rsp_collector credit overrun");
      assert (!(tag_full && issue_fire && !tag_pop))
        else $error("aes_rsp_collector tag overflow");
      assert (!(rsp_full && tag_pop && !rsp_pop))
        else $error("aes_rsp_collector rsp overflow");
    end
  end
`endif

endmodule

// File: tb/tb_aes_rsp_collector.sv
// Self-checking bench for aes_rsp_collector.
// Directed steps plus random traffic against a queue model.
module tb_aes_rsp_collector;
  import aes_pkg::*;

  localparam int DEPTH = 4;
  localparam int ID_W  = 4;

  logic eph1;
  logic reset;
  int   checks;
  int   errors;

  aes_rsp_collector_if #(.DEPTH(DEPTH), .ID_W(ID_W)) bus ();

  aes_rsp_collector #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .eph1  (eph1),
    .reset (reset),
    .bus   (bus)
  );

  initial eph1 = 1'b0;
  always #5 eph1 = ~eph1;

  aes_tag_t tq[$];
  aes_rsp_t rq[$];
  int       m_out;
  bit       m_orph;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rsp_valid", 128'(bus.rsp_valid), 128'(rq.size() > 0));
    if (rq.size() > 0) begin
      chk("rsp_data", bus.rsp_data, rq[0].data);
      chk("rsp_func", 128'(bus.rsp_func), 128'(rq[0].func));
      chk("rsp_id", 128'(bus.rsp_id), 128'(rq[0].id));
    end
    chk("outstanding", 128'(bus.outstanding), 128'(m_out));
    chk("issue_ready", 128'(bus.issue_ready), 128'(m_out < DEPTH));
    chk("err_orphan", 128'(bus.err_orphan), 128'(m_orph));
  endtask

  task automatic idle();
    bus.issue_valid   = 1'b0;
    bus.issue_func    = '0;
    bus.issue_id      = '0;
    bus.call_complete = 1'b0;
    bus.ciphertext    = '0;
    bus.plaintext     = '0;
    bus.rsp_ready     = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance the model by one cycle from current inputs, then clock.
  task automatic tick();
    bit       do_rp;
    bit       do_cc;
    bit       do_is;
    aes_tag_t t;
    aes_rsp_t r;
    do_rp = bus.rsp_ready && (rq.size() > 0);
    do_cc = bus.call_complete && (tq.size() > 0);
    do_is = bus.issue_valid && (m_out < DEPTH);
    if (bus.call_complete && tq.size() == 0) m_orph = 1'b1;
    if (do_rp) rq.delete(0);
    if (do_cc) begin
      t = tq.pop_front();
      r.data = t.func[0] ? bus.ciphertext : bus.plaintext;
      r.func = t.func;
      r.id   = t.id;
      rq.push_back(r);
    end
    if (do_is) begin
      t.func = bus.issue_func;
      t.id   = bus.issue_id;
      tq.push_back(t);
    end
    m_out = m_out + int'(do_is) - int'(do_rp);
    @(posedge eph1);
    #1;
    check_all();
  endtask

  task automatic issue(input logic [2:0] f, input logic [3:0] id);
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_func  = f;
    bus.issue_id    = id;
    tick();
  endtask

  task automatic complete(input logic [127:0] ct, input logic [127:0] pt);
    idle();
    bus.call_complete = 1'b1;
    bus.ciphertext    = ct;
    bus.plaintext     = pt;
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((tq.size() > 0 || rq.size() > 0) && n < 50) begin
      idle();
      bus.rsp_ready     = 1'b1;
      bus.call_complete = (tq.size() > 0);
      bus.ciphertext    = rnd128();
      bus.plaintext     = rnd128();
      tick();
      n++;
    end
    chk("drain_done", 128'(tq.size() + rq.size()), 128'(0));
  endtask

  task automatic reset_now();
    reset = 1'b0;
    #1;
    tq.delete();
    rq.delete();
    m_out  = 0;
    m_orph = 1'b0;
    chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    chk("rst_rsp_data", bus.rsp_data, 128'(0));
    chk("rst_rsp_func", 128'(bus.rsp_func), 128'(0));
    chk("rst_rsp_id", 128'(bus.rsp_id), 128'(0));
    chk("rst_outstanding", 128'(bus.outstanding), 128'(0));
    chk("rst_err_orphan", 128'(bus.err_orphan), 128'(0));
    chk("rst_issue_ready", 128'(bus.issue_ready), 128'(1));
    idle();
    @(negedge eph1);
    reset = 1'b1;
    @(posedge eph1);
    #1;
    check_all();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_out  = 0;
    m_orph = 1'b0;
    idle();
    reset = 1'b1;
    #2;
    reset_now();

    // Encrypt path
    issue(3'd1, 4'd3);
    chk("enc_out_issued", 128'(bus.outstanding), 128'(1));
    complete(128'h69c4e0d86a7b0430d8cdb78070b4c55a, rnd128());
    chk("enc_data", bus.rsp_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("enc_id", 128'(bus.rsp_id), 128'(3));
    chk("enc_func", 128'(bus.rsp_func), 128'(1));
    chk("enc_out_done", 128'(bus.outstanding), 128'(1));
    idle();
    bus.rsp_ready = 1'b1;
    tick();
    chk("enc_out_pop", 128'(bus.outstanding), 128'(0));

    // Decrypt select
    issue(3'd2, 4'd5);
    complete({128{1'b1}}, 128'h00112233445566778899aabbccddeeff);
    chk("dec_data", bus.rsp_data, 128'h00112233445566778899aabbccddeeff);
    chk("dec_func", 128'(bus.rsp_func), 128'(2));
    drain();

    // Credit full
    for (int i = 0; i < DEPTH; i++) issue(3'(i), 4'(i + 8));
    for (int i = 0; i < DEPTH; i++) complete(rnd128(), rnd128());
    chk("full_ready", 128'(bus.issue_ready), 128'(0));
    chk("full_out", 128'(bus.outstanding), 128'(DEPTH));
    issue(3'd1, 4'hf);
    chk("full_reject", 128'(bus.outstanding), 128'(DEPTH));
    idle();
    bus.rsp_ready = 1'b1;
    tick();
    chk("full_ready_back", 128'(bus.issue_ready), 128'(1));
    drain();

    // Ordering and backpressure
    issue(3'd4, 4'd1);
    issue(3'd5, 4'd2);
    issue(3'd4, 4'd3);
    for (int i = 0; i < 3; i++) complete(rnd128(), rnd128());
    idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_id", 128'(bus.rsp_id), 128'(1));
    end
    for (int i = 1; i <= 3; i++) begin
      chk("order_id", 128'(bus.rsp_id), 128'(i));
      idle();
      bus.rsp_ready = 1'b1;
      tick();
    end

    // Simultaneous issue, completion and pop
    issue(3'd1, 4'd6);
    issue(3'd0, 4'd7);
    complete(rnd128(), rnd128());
    chk("sim_pre_out", 128'(bus.outstanding), 128'(2));
    idle();
    bus.issue_valid   = 1'b1;
    bus.issue_func    = 3'd3;
    bus.issue_id      = 4'd9;
    bus.call_complete = 1'b1;
    bus.ciphertext    = rnd128();
    bus.plaintext     = rnd128();
    bus.rsp_ready     = 1'b1;
    tick();
    chk("sim_out", 128'(bus.outstanding), 128'(2));
    drain();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      idle();
      bus.issue_valid   = 1'($urandom_range(0, 1));
      bus.issue_func    = 3'($urandom);
      bus.issue_id      = 4'($urandom);
      bus.call_complete = (tq.size() > 0) && ($urandom_range(0, 2) != 0);
      bus.ciphertext    = rnd128();
      bus.plaintext     = rnd128();
      bus.rsp_ready     = 1'($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Orphan with nothing pending
    complete(rnd128(), rnd128());
    chk("orphan_flag", 128'(bus.err_orphan), 128'(1));
    chk("orphan_no_rsp", 128'(bus.rsp_valid), 128'(0));

    // Orphan in the same cycle as the first issue
    reset_now();
    idle();
    bus.issue_valid   = 1'b1;
    bus.issue_func    = 3'd1;
    bus.issue_id      = 4'd2;
    bus.call_complete = 1'b1;
    tick();
    chk("orphan_same_cycle", 128'(bus.err_orphan), 128'(1));
    chk("orphan_same_out", 128'(bus.outstanding), 128'(1));

    // Reset mid-stream with two outstanding
    issue(3'd0, 4'd4);
    complete(rnd128(), rnd128());
    chk("mid_out", 128'(bus.outstanding), 128'(2));
    reset_now();
    complete(rnd128(), rnd128());
    chk("post_rst_orphan", 128'(bus.err_orphan), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
